// File: rtl/aes_inv_pkg.sv
// Shared AES-128 decryption constants: FSM encoding, round count,
// Rcon and the forward/inverse S-box tables.
package aes_inv_pkg;

    localparam int NR = 10;
    localparam logic [3:0] CNT_LAST = 4'(NR - 1);

    typedef enum logic [1:0] {
        IDLE,
        KEYEXP,
        ROUND,
        DONE
    } state_t;

    localparam logic [7:0] RCON [NR] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
        8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // GF(2^8) multiply by a 4-bit constant (enough for 9, b, d, e)
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [3:0] k);
        logic [7:0] x2;
        logic [7:0] x4;
        logic [7:0] x8;
        x2 = xtime(a);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return (k[0] ? a : 8'h00) ^ (k[1] ? x2 : 8'h00)
             ^ (k[2] ? x4 : 8'h00) ^ (k[3] ? x8 : 8'h00);
    endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One combinational inverse AES round; i_last skips InvMixColumns.
module aes_inv_round
    import aes_inv_pkg::*;
(
    input  logic [127:0] i_state,
    input  logic [127:0] i_rk,
    input  logic         i_last,
    output logic [127:0] o_state
);

    logic [7:0] w_ark [16];
    logic [7:0] w_mc  [16];

    // byte n = row (n%4), column (n/4); row r rotates right by r
    for (genvar gi = 0; gi < 16; gi++) begin : g_byte
        localparam int R   = gi % 4;
        localparam int C   = gi / 4;
        localparam int SRC = R + 4 * ((C - R + 4) % 4);
        assign w_ark[gi] = INV_SBOX[i_state[127-8*SRC -: 8]]
                         ^ i_rk[127-8*gi -: 8];
    end

    for (genvar gc = 0; gc < 4; gc++) begin : g_col
        logic [7:0] w_a0, w_a1, w_a2, w_a3;
        assign w_a0 = w_ark[4*gc];
        assign w_a1 = w_ark[4*gc+1];
        assign w_a2 = w_ark[4*gc+2];
        assign w_a3 = w_ark[4*gc+3];
        assign w_mc[4*gc]   = gmul(w_a0, 4'he) ^ gmul(w_a1, 4'hb)
                            ^ gmul(w_a2, 4'hd) ^ gmul(w_a3, 4'h9);
        assign w_mc[4*gc+1] = gmul(w_a0, 4'h9) ^ gmul(w_a1, 4'he)
                            ^ gmul(w_a2, 4'hb) ^ gmul(w_a3, 4'hd);
        assign w_mc[4*gc+2] = gmul(w_a0, 4'hd) ^ gmul(w_a1, 4'h9)
                            ^ gmul(w_a2, 4'he) ^ gmul(w_a3, 4'hb);
        assign w_mc[4*gc+3] = gmul(w_a0, 4'hb) ^ gmul(w_a1, 4'hd)
                            ^ gmul(w_a2, 4'h9) ^ gmul(w_a3, 4'he);
    end

    for (genvar go = 0; go < 16; go++) begin : g_out
        assign o_state[127-8*go -: 8] = i_last ? w_ark[go] : w_mc[go];
    end

endmodule

// File: rtl/aes_inv_top.sv
// Iterative AES-128 decryptor: 10-cycle forward key expansion,
// then 10 inverse rounds, one valid pulse per block.
module aes_inv_top
    import aes_inv_pkg::*;
(
    input  logic         AES_clk,
    input  logic         AES_rst,
    input  logic         AES_en,
    input  logic [127:0] AES_data_in,
    input  logic [127:0] AES_key_in,
    output logic [127:0] AES_data_out,
    output logic         AES_data_out_valid,
    output logic         AES_busy
);

    state_t       r_state;
    state_t       w_next;
    logic [3:0]   r_cnt;
    logic [127:0] r_ct;
    logic [127:0] r_st;
    logic [127:0] r_out;
    logic [127:0] r_rk [NR+1];

    logic [127:0] w_rk_sel;
    logic [31:0]  w_k0, w_k1, w_k2, w_k3;
    logic [31:0]  w_rot, w_sub;
    logic [31:0]  w_n0, w_n1, w_n2, w_n3;
    logic [127:0] w_rk_next;
    logic [127:0] w_round_out;
    logic         w_last;

    // same index walks rk1..rk10 forward, then rk9..rk0 back
    assign w_rk_sel = r_rk[r_cnt];
    assign w_k0 = w_rk_sel[127:96];
    assign w_k1 = w_rk_sel[95:64];
    assign w_k2 = w_rk_sel[63:32];
    assign w_k3 = w_rk_sel[31:0];
    assign w_rot = {w_k3[23:0], w_k3[31:24]};
    assign w_sub = {SBOX[w_rot[31:24]], SBOX[w_rot[23:16]],
                    SBOX[w_rot[15:8]],  SBOX[w_rot[7:0]]};
    assign w_n0 = w_k0 ^ w_sub ^ {RCON[r_cnt], 24'h0};
    assign w_n1 = w_k1 ^ w_n0;
    assign w_n2 = w_k2 ^ w_n1;
    assign w_n3 = w_k3 ^ w_n2;
    assign w_rk_next = {w_n0, w_n1, w_n2, w_n3};

    assign w_last = (r_cnt == 4'd0);

    aes_inv_round u_round (
        .i_state (r_st),
        .i_rk    (w_rk_sel),
        .i_last  (w_last),
        .o_state (w_round_out)
    );

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (AES_en) w_next = KEYEXP;
            KEYEXP:  if (r_cnt == CNT_LAST) w_next = ROUND;
            ROUND:   if (w_last) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge AES_clk) begin
        if (AES_rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_ct    <= '0;
            r_st    <= '0;
            r_out   <= '0;
            for (int i = 0; i <= NR; i++) r_rk[i] <= '0;
        end else begin
            r_state <= w_next;
            unique case (r_state)
                IDLE: begin
                    if (AES_en) begin
                        r_ct    <= AES_data_in;
                        r_rk[0] <= AES_key_in;
                        r_cnt   <= '0;
                    end
                end
                KEYEXP: begin
                    r_rk[r_cnt + 4'd1] <= w_rk_next;
                    if (r_cnt == CNT_LAST) r_st <= r_ct ^ w_rk_next;
                    else r_cnt <= r_cnt + 4'd1;
                end
                ROUND: begin
                    r_st <= w_round_out;
                    if (w_last) r_out <= w_round_out;
                    else r_cnt <= r_cnt - 4'd1;
                end
                DONE: begin
                end
                default: begin
                end
            endcase
        end
    end

    assign AES_data_out       = r_out;
    assign AES_data_out_valid = (r_state == DONE);
    assign AES_busy           = (r_state != IDLE);

endmodule

// File: tb/tb_aes_inv_top.sv
// Bench for aes_inv_top: known-answer vectors, timing, reset abort and
// random round trips through a behavioural AES-128 encryptor.
module tb_aes_inv_top;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         en = 1'b0;
    logic [127:0] din = '0;
    logic [127:0] key = '0;
    logic [127:0] dout;
    logic         valid;
    logic         busy;

    int checks = 0;
    int errors = 0;
    logic [7:0] sb [256];

    localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] K2  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT2 = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT2 = 128'h3243f6a8885a308d313198a2e0370734;

    aes_inv_top dut (
        .AES_clk            (clk),
        .AES_rst            (rst),
        .AES_en             (en),
        .AES_data_in        (din),
        .AES_key_in         (key),
        .AES_data_out       (dout),
        .AES_data_out_valid (valid),
        .AES_busy           (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box from its definition: GF inverse followed by the affine map
    task automatic build_sbox();
        logic [7:0] inv;
        logic [7:0] b;
        logic [7:0] s;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (x != 0 && gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            b = inv;
            s = inv;
            for (int r = 0; r < 4; r++) begin
                b = {b[6:0], b[7]};
                s = s ^ b;
            end
            sb[x] = s ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] aes_enc(input logic [127:0] pt, input logic [127:0] k);
        logic [31:0]  w [44];
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [31:0]  tmp;
        logic [7:0]   rc;
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] res;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sb[tmp[31:24]], sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]]}
                    ^ {rc, 24'h0};
                rc = gf_mul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int i = 0; i < 16; i++)
            s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++)
                t[i] = sb[s[(i%4) + 4*(((i/4) + (i%4)) % 4)]];
            for (int c = 0; c < 4; c++) begin
                a0 = t[4*c];
                a1 = t[4*c+1];
                a2 = t[4*c+2];
                a3 = t[4*c+3];
                if (r == 10) begin
                    s[4*c]   = a0;
                    s[4*c+1] = a1;
                    s[4*c+2] = a2;
                    s[4*c+3] = a3;
                end else begin
                    s[4*c]   = gf_mul(a0, 8'h02) ^ gf_mul(a1, 8'h03) ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ gf_mul(a1, 8'h02) ^ gf_mul(a2, 8'h03) ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ gf_mul(a2, 8'h02) ^ gf_mul(a3, 8'h03);
                    s[4*c+3] = gf_mul(a0, 8'h03) ^ a1 ^ a2 ^ gf_mul(a3, 8'h02);
                end
            end
            for (int i = 0; i < 16; i++)
                s[i] = s[i] ^ w[4*r + i/4][31-8*(i%4) -: 8];
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Starts one block from IDLE; lat is the cycle of the valid pulse, -1 on timeout
    task automatic run_block(input logic [127:0] k, input logic [127:0] ct,
                             output logic [127:0] res, output int lat);
        @(negedge clk);
        din = ct;
        key = k;
        en  = 1'b1;
        @(posedge clk);
        lat = -1;
        res = '0;
        for (int c = 1; c <= 40 && lat < 0; c++) begin
            @(negedge clk);
            if (c == 1) en = 1'b0;
            if (valid) begin
                lat = c;
                res = dout;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        en  = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (dout !== 128'h0) begin
            errors++;
            $display("FAIL reset_dout got %h want 0", dout);
        end
        checks++;
        if (valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid got %b want 0", valid);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy got %b want 0", busy);
        end
        en  = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_kat_timing();
        @(negedge clk);
        din = CT1;
        key = K1;
        en  = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 24; c++) begin
            @(negedge clk);
            if (c == 1) en = 1'b0;
            checks++;
            if (valid !== (c == 21)) begin
                errors++;
                $display("FAIL kat1_valid cycle %0d got %b want %b", c, valid, c == 21);
            end
            checks++;
            if (busy !== (c <= 21)) begin
                errors++;
                $display("FAIL kat1_busy cycle %0d got %b want %b", c, busy, c <= 21);
            end
            if (c == 21) begin
                checks++;
                if (dout !== PT1) begin
                    errors++;
                    $display("FAIL kat1_data got %h want %h", dout, PT1);
                end
            end
        end
    endtask

    task automatic test_kat2_hold();
        logic [127:0] res;
        int lat;
        run_block(K2, CT2, res, lat);
        checks++;
        if (lat != 21 || res !== PT2) begin
            errors++;
            $display("FAIL kat2 lat %0d data %h want lat 21 data %h", lat, res, PT2);
        end
        din = rnd128();
        key = rnd128();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (dout !== PT2 || valid !== 1'b0) begin
                errors++;
                $display("FAIL hold_out got %h/%b want %h/0", dout, valid, PT2);
            end
        end
    endtask

    task automatic test_input_change();
        @(negedge clk);
        din = CT2;
        key = K2;
        en  = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 23; c++) begin
            @(negedge clk);
            din = rnd128();
            key = rnd128();
            en  = (c < 21) ? 1'($urandom_range(0, 1)) : 1'b0;
            if (c == 21) begin
                checks++;
                if (valid !== 1'b1 || dout !== PT2) begin
                    errors++;
                    $display("FAIL input_change got %b/%h want 1/%h", valid, dout, PT2);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        bit drained;
        @(negedge clk);
        din = CT1;
        key = K1;
        en  = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            checks++;
            if (valid !== (c == 21 || c == 43)) begin
                errors++;
                $display("FAIL b2b_valid cycle %0d got %b", c, valid);
            end
            checks++;
            if (busy !== !(c == 22 || c == 44)) begin
                errors++;
                $display("FAIL b2b_busy cycle %0d got %b", c, busy);
            end
            if (c >= 21) begin
                checks++;
                if (dout !== PT1) begin
                    errors++;
                    $display("FAIL b2b_data cycle %0d got %h want %h", c, dout, PT1);
                end
            end
        end
        en = 1'b0;
        drained = 1'b0;
        for (int c = 0; c < 30 && !drained; c++) begin
            @(negedge clk);
            if (!busy) drained = 1'b1;
        end
        checks++;
        if (!drained) begin
            errors++;
            $display("FAIL b2b_drain busy still %b want 0", busy);
        end
    endtask

    task automatic test_mid_reset();
        logic [127:0] res;
        int lat;
        int pulses;
        @(negedge clk);
        din = CT2;
        key = K2;
        en  = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (c == 1) en = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (dout !== 128'h0 || valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midrst got %h/%b/%b want 0/0/0", dout, valid, busy);
        end
        pulses = 0;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            if (valid || busy) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL midrst_quiet got %0d active cycles want 0", pulses);
        end
        run_block(K1, CT1, res, lat);
        checks++;
        if (lat != 21 || res !== PT1) begin
            errors++;
            $display("FAIL midrst_next lat %0d data %h want lat 21 data %h", lat, res, PT1);
        end
    endtask

    task automatic test_random();
        logic [127:0] pt;
        logic [127:0] k;
        logic [127:0] res;
        int lat;
        for (int n = 0; n < 1000; n++) begin
            pt = rnd128();
            k  = rnd128();
            run_block(k, aes_enc(pt, k), res, lat);
            checks++;
            if (lat != 21 || res !== pt) begin
                errors++;
                $display("FAIL random_%0d lat %0d data %h want lat 21 data %h",
                         n, lat, res, pt);
            end
        end
    endtask

    initial begin
        build_sbox();
        test_reset();
        test_kat_timing();
        test_kat2_hold();
        test_input_change();
        test_back_to_back();
        test_mid_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
